// File: rtl/centroid_divider_pkg.sv
// rtl/centroid_divider_pkg.sv - k-means widths, divider FSM states and coordinate saturation helper
package kmeans_pkg;

   localparam int CORD_WIDTH       = 13;
   localparam int ACCUM_CORD_WIDTH = 22;
   localparam int NUM_CORDS        = 7;
   localparam int ACCUM_WIDTH      = NUM_CORDS * ACCUM_CORD_WIDTH;
   localparam int DATA_WIDTH       = NUM_CORDS * CORD_WIDTH;
   localparam int COUNT_WIDTH      = 10;
   localparam int CENTROID_NUM     = 8;
   localparam int IDX_WIDTH        = $clog2(CENTROID_NUM);
   localparam int CNT_BITS         = $clog2(ACCUM_CORD_WIDTH);

   localparam logic signed [CORD_WIDTH-1:0] CORD_MAX = 13'sh0FFF;
   localparam logic signed [CORD_WIDTH-1:0] CORD_MIN = 13'sh1000;

   typedef enum logic [2:0] {IDLE, READ, LOAD, DIVIDE, OUTPUT, DONE} div_state_t;

   // Signed magnitude back to two's complement; negative side reaches one further than positive.
   function automatic logic [CORD_WIDTH-1:0] saturate(input logic neg,
                                                       input logic [ACCUM_CORD_WIDTH-1:0] mag);
      logic [ACCUM_CORD_WIDTH-1:0] lim;
      lim = neg ? ACCUM_CORD_WIDTH'(4096) : ACCUM_CORD_WIDTH'(4095);
      if (mag > lim) begin
         return neg ? CORD_MIN : CORD_MAX;
      end
      return neg ? (~mag[CORD_WIDTH-1:0] + CORD_WIDTH'(1)) : mag[CORD_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/centroid_divider_if.sv
// rtl/centroid_divider_if.sv - control, storage read and result handshake bundle of centroid_divider
interface centroid_divider_if;
   import kmeans_pkg::*;

   logic                   start;
   logic                   busy;
   logic                   done;
   logic                   rd_en;
   logic [IDX_WIDTH-1:0]   rd_addr;
   logic [ACCUM_WIDTH-1:0] accum_data;
   logic [COUNT_WIDTH-1:0] count_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [IDX_WIDTH-1:0]   out_idx;
   logic [DATA_WIDTH-1:0]  out_point;
   logic                   out_empty;

   modport master (
      input  start, accum_data, count_data, out_ready,
      output busy, done, rd_en, rd_addr, out_valid, out_idx, out_point, out_empty
   );

   modport slave (
      output start, accum_data, count_data, out_ready,
      input  busy, done, rd_en, rd_addr, out_valid, out_idx, out_point, out_empty
   );

endinterface

// File: rtl/centroid_divider_serial_divider.sv
// rtl/centroid_divider_serial_divider.sv - unsigned restoring divider, one quotient bit per step
module serial_divider
   import kmeans_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        load,
   input  logic                        busy,
   input  logic [ACCUM_CORD_WIDTH-1:0] dividend,
   input  logic [COUNT_WIDTH-1:0]      divisor,
   output logic [ACCUM_CORD_WIDTH-1:0] quotient
);

   logic [ACCUM_CORD_WIDTH-1:0] q_reg;
   logic [COUNT_WIDTH-1:0]      rem_reg;
   logic [COUNT_WIDTH-1:0]      div_reg;
   logic [COUNT_WIDTH:0]        trial;
   logic [COUNT_WIDTH-1:0]      diff;
   logic                        fits;

   // quotient is the value after the current step, so the caller can register the final bit directly
   always_comb begin
      trial    = {rem_reg, q_reg[ACCUM_CORD_WIDTH-1]};
      fits     = trial >= {1'b0, div_reg};
      diff     = trial[COUNT_WIDTH-1:0] - div_reg;
      quotient = {q_reg[ACCUM_CORD_WIDTH-2:0], fits};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_reg   <= '0;
         rem_reg <= '0;
         div_reg <= '0;
      end else if (load) begin
         q_reg   <= dividend;
         rem_reg <= '0;
         div_reg <= divisor;
      end else if (busy) begin
         q_reg   <= quotient;
         rem_reg <= fits ? diff : trial[COUNT_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/centroid_divider.sv
// rtl/centroid_divider.sv - per-centroid sum/count update pass; CENTROID_DIV_ROUND_EN selects round-half-away-from-zero
module centroid_divider
   import kmeans_pkg::*;
#(
   parameter int accum_width      = 7 * 22,
   parameter int accum_cord_width = 22,
   parameter int dataWidth        = 91,
   parameter int cordinate_width  = 13,
   parameter int centroid_num     = 8,
   parameter int count_width      = 10,
   parameter int idx_width        = $clog2(centroid_num)
) (
   input  logic               clk,
   input  logic               rst_n,
   centroid_divider_if.master bus
);

   localparam int CORDS = dataWidth / cordinate_width;
   localparam logic [CNT_BITS-1:0]  LAST_BIT = CNT_BITS'(accum_cord_width - 1);
   localparam logic [idx_width-1:0] LAST_IDX = idx_width'(centroid_num - 1);
   localparam logic [idx_width-1:0] IDX_ONE  = idx_width'(1);

   div_state_t             state;
   logic [idx_width-1:0]   index;
   logic [CNT_BITS-1:0]    bit_cnt;
   logic [CORDS-1:0]       neg;
   logic [accum_width-1:0] accum_word;
   logic [count_width-1:0] count_word;
   logic [dataWidth-1:0]   result;
   logic                   div_load;
   logic                   div_step;

   assign accum_word = bus.accum_data;
   assign count_word = bus.count_data;
   assign div_load   = (state == LOAD);
   assign div_step   = (state == DIVIDE);

   for (genvar g = 0; g < CORDS; g++) begin : g_cord
      logic [accum_cord_width-1:0] sum;
      logic [accum_cord_width-1:0] mag;
      logic [accum_cord_width-1:0] dividend;
      logic [accum_cord_width-1:0] quotient;

      assign sum = accum_word[g*accum_cord_width +: accum_cord_width];
      // -2^21 maps to 2^21, which still fits the unsigned dividend
      assign mag = sum[accum_cord_width-1] ? (~sum + {{(accum_cord_width-1){1'b0}}, 1'b1}) : sum;

`ifdef CENTROID_DIV_ROUND_EN
      assign dividend = mag + {{(accum_cord_width - count_width + 1){1'b0}}, count_word[count_width-1:1]};
`else
      assign dividend = mag;
`endif

      serial_divider u_div (
         .clk      (clk),
         .rst_n    (rst_n),
         .load     (div_load),
         .busy     (div_step),
         .dividend (dividend),
         .divisor  (count_word),
         .quotient (quotient)
      );

      assign result[g*cordinate_width +: cordinate_width] = saturate(neg[g], quotient);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         index         <= '0;
         bit_cnt       <= '0;
         neg           <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.rd_en     <= 1'b0;
         bus.rd_addr   <= '0;
         bus.out_valid <= 1'b0;
         bus.out_idx   <= '0;
         bus.out_point <= '0;
         bus.out_empty <= 1'b0;
      end else begin
         bus.done  <= 1'b0;
         bus.rd_en <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  index       <= '0;
                  bus.rd_addr <= '0;
                  bus.rd_en   <= 1'b1;
                  bus.busy    <= 1'b1;
                  state       <= READ;
               end
            end
            READ: state <= LOAD;
            LOAD: begin
               for (int i = 0; i < CORDS; i++) begin
                  neg[i] <= accum_word[i*accum_cord_width + accum_cord_width - 1];
               end
               bus.out_idx <= index;
               if (count_word == '0) begin
                  bus.out_point <= '0;
                  bus.out_empty <= 1'b1;
                  bus.out_valid <= 1'b1;
                  state         <= OUTPUT;
               end else begin
                  bit_cnt <= '0;
                  state   <= DIVIDE;
               end
            end
            DIVIDE: begin
               bit_cnt <= bit_cnt + CNT_BITS'(1);
               if (bit_cnt == LAST_BIT) begin
                  bus.out_point <= result;
                  bus.out_empty <= 1'b0;
                  bus.out_valid <= 1'b1;
                  state         <= OUTPUT;
               end
            end
            OUTPUT: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  if (index == LAST_IDX) begin
                     bus.done <= 1'b1;
                     state    <= DONE;
                  end else begin
                     index       <= index + IDX_ONE;
                     bus.rd_addr <= index + IDX_ONE;
                     bus.rd_en   <= 1'b1;
                     state       <= READ;
                  end
               end
            end
            DONE: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_centroid_divider.sv
// tb/tb_centroid_divider.sv - randomized self-checking bench for centroid_divider against an arithmetic model
module tb_centroid_divider;
   import kmeans_pkg::*;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_checks;
   int   n_pass;

   int                    sums   [CENTROID_NUM][NUM_CORDS];
   int                    counts [CENTROID_NUM];
   logic [DATA_WIDTH-1:0] cap_point [CENTROID_NUM];
   logic                  cap_empty [CENTROID_NUM];

   centroid_divider_if bus ();

   centroid_divider dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   function automatic logic [ACCUM_WIDTH-1:0] pack_accum(input int a);
      logic [ACCUM_WIDTH-1:0] w;
      for (int i = 0; i < NUM_CORDS; i++) begin
         w[i*ACCUM_CORD_WIDTH +: ACCUM_CORD_WIDTH] = ACCUM_CORD_WIDTH'(sums[a][i]);
      end
      return w;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] exp_point(input int a);
      logic [DATA_WIDTH-1:0] p;
      int mag;
      int q;
      p = '0;
      if (counts[a] == 0) return p;
      for (int i = 0; i < NUM_CORDS; i++) begin
         mag = (sums[a][i] < 0) ? -sums[a][i] : sums[a][i];
`ifdef CENTROID_DIV_ROUND_EN
         mag = mag + counts[a] / 2;
`endif
         q = mag / counts[a];
         if (sums[a][i] < 0) q = -q;
         if (q > 4095) q = 4095;
         if (q < -4096) q = -4096;
         p[i*CORD_WIDTH +: CORD_WIDTH] = CORD_WIDTH'(q);
      end
      return p;
   endfunction

   // Storage: data is valid only in the cycle after rd_en, garbage otherwise
   initial begin : storage
      int a;
      bus.accum_data = '0;
      bus.count_data = '0;
      forever begin
         @(posedge clk);
         if (bus.rd_en === 1'b1) begin
            a = int'(bus.rd_addr);
            #1;
            bus.accum_data = pack_accum(a);
            bus.count_data = COUNT_WIDTH'(counts[a]);
         end else begin
            #1;
            for (int i = 0; i < NUM_CORDS; i++) begin
               bus.accum_data[i*ACCUM_CORD_WIDTH +: ACCUM_CORD_WIDTH] = ACCUM_CORD_WIDTH'($urandom);
            end
            bus.count_data = COUNT_WIDTH'($urandom);
         end
      end
   end

   task automatic fill_random(input bit allow_zero);
      for (int a = 0; a < CENTROID_NUM; a++) begin
         counts[a] = (allow_zero && $urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 1023));
         for (int i = 0; i < NUM_CORDS; i++) begin
            if ($urandom_range(0, 2) == 0) sums[a][i] = int'($urandom_range(0, 4194303)) - 2097152;
            else                           sums[a][i] = int'($urandom_range(0, 131070)) - 65535;
         end
      end
   endtask

   // mode 0: ready high, 1: random ready, 2: stall centroid 2 for 10 cycles
   task automatic run_pass(input int mode, input bit pulse_mid, output int start_cyc, output int done_cyc);
      int got = 0;
      int rd_cyc = -100;
      int budget = 0;
      int ndone = 0;
      int stall_left = 0;
      int lat;
      bit first = 1'b1;
      bit expect_rd = 1'b0;
      bit stalling = 1'b0;
      logic [DATA_WIDTH-1:0] held = '0;
      done_cyc = -1;
      @(negedge clk);
      bus.start = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      expect_rd = 1'b1;
      while (got < CENTROID_NUM && budget < 3000) begin
         if (expect_rd) begin
            n_checks++;
            if (bus.rd_en !== 1'b1 || bus.rd_addr !== IDX_WIDTH'(got))
               $display("FAIL read_issue: rd_en=%b rd_addr=%0d want rd_en=1 rd_addr=%0d", bus.rd_en, bus.rd_addr, got);
            else n_pass++;
            expect_rd = 1'b0;
         end
         if (bus.rd_en === 1'b1) rd_cyc = cyc;
         if (bus.done === 1'b1) begin
            ndone++;
            done_cyc = cyc;
         end
         if (stalling) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_point !== held || bus.rd_en !== 1'b0)
               $display("FAIL stall_hold: valid=%b rd_en=%b point=%h want valid=1 rd_en=0 point=%h",
                        bus.out_valid, bus.rd_en, bus.out_point, held);
            else n_pass++;
         end
         if (bus.out_valid === 1'b1 && first) begin
            first = 1'b0;
            lat = (counts[got] == 0) ? 2 : 24;
            n_checks++;
            if (cyc - rd_cyc !== lat) $display("FAIL latency[%0d]: got %0d want %0d", got, cyc - rd_cyc, lat);
            else n_pass++;
            n_checks++;
            if (bus.out_idx !== IDX_WIDTH'(got)) $display("FAIL out_idx: got %0d want %0d", bus.out_idx, got);
            else n_pass++;
            n_checks++;
            if (bus.out_point !== exp_point(got))
               $display("FAIL out_point[%0d]: got %h want %h", got, bus.out_point, exp_point(got));
            else n_pass++;
            n_checks++;
            if (bus.out_empty !== (counts[got] == 0))
               $display("FAIL out_empty[%0d]: got %b want %b", got, bus.out_empty, counts[got] == 0);
            else n_pass++;
            cap_point[got] = bus.out_point;
            cap_empty[got] = bus.out_empty;
            if (mode == 2 && got == 2) begin
               stall_left = 10;
               held = bus.out_point;
            end
         end
         bus.start = (pulse_mid && got == 3) ? 1'b1 : 1'b0;
         if (stall_left > 0) begin
            bus.out_ready = 1'b0;
            stall_left--;
            stalling = 1'b1;
         end else begin
            stalling = 1'b0;
            bus.out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            got++;
            first = 1'b1;
            expect_rd = (got < CENTROID_NUM);
         end
         @(negedge clk);
         budget++;
      end
      bus.start = 1'b0;
      n_checks++;
      if (got != CENTROID_NUM) $display("FAIL pass_timeout: got %0d results want %0d", got, CENTROID_NUM);
      else n_pass++;
      for (int k = 0; k < 4; k++) begin
         if (bus.done === 1'b1) begin
            ndone++;
            done_cyc = cyc;
         end
         @(negedge clk);
      end
      n_checks++;
      if (ndone != 1) $display("FAIL done_pulses: got %0d want 1", ndone);
      else n_pass++;
      n_checks++;
      if (bus.busy !== 1'b0) $display("FAIL busy_after_pass: got %b want 0", bus.busy);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL reset_ctrl: busy=%b done=%b want 0 0", bus.busy, bus.done);
      else n_pass++;
      n_checks++;
      if (bus.rd_en !== 1'b0 || bus.rd_addr !== '0) $display("FAIL reset_rd: rd_en=%b rd_addr=%0d want 0 0", bus.rd_en, bus.rd_addr);
      else n_pass++;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.out_idx !== '0 || bus.out_empty !== 1'b0)
         $display("FAIL reset_out: valid=%b idx=%0d empty=%b want 0 0 0", bus.out_valid, bus.out_idx, bus.out_empty);
      else n_pass++;
      n_checks++;
      if (bus.out_point !== '0) $display("FAIL reset_point: got %h want 0", bus.out_point);
      else n_pass++;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0) $display("FAIL idle_no_start: busy=%b rd_en=%b want 0 0", bus.busy, bus.rd_en);
      else n_pass++;
   endtask

   task automatic test_directed();
      int s;
      int d;
      logic [CORD_WIDTH-1:0] want_m7;
`ifdef CENTROID_DIV_ROUND_EN
      want_m7 = 13'h1FFC;
`else
      want_m7 = 13'h1FFD;
`endif
      for (int a = 0; a < CENTROID_NUM; a++) begin
         counts[a] = 1;
         for (int i = 0; i < NUM_CORDS; i++) sums[a][i] = 0;
      end
      sums[0][0] = 300;        counts[0] = 3;
      sums[1][0] = -7;         counts[1] = 2;
      sums[2][0] = 1 << 20;
      sums[3][0] = -(1 << 21);
      sums[4][0] = -4096;
      sums[5][0] = 1234;       counts[5] = 0;
      sums[6][3] = -12345;     counts[6] = 77;
      sums[7][6] = 99999;      counts[7] = 1023;
      run_pass(0, 1'b0, s, d);
      n_checks++;
      if (cap_point[0] !== {{(DATA_WIDTH-CORD_WIDTH){1'b0}}, 13'h0064} || cap_empty[0] !== 1'b0)
         $display("FAIL dir_300_div_3: got %h empty=%b want 64 empty=0", cap_point[0], cap_empty[0]);
      else n_pass++;
      n_checks++;
      if (cap_point[1][CORD_WIDTH-1:0] !== want_m7) $display("FAIL dir_m7_div_2: got %h want %h", cap_point[1][CORD_WIDTH-1:0], want_m7);
      else n_pass++;
      n_checks++;
      if (cap_point[2][CORD_WIDTH-1:0] !== 13'h0FFF) $display("FAIL dir_sat_pos: got %h want 0fff", cap_point[2][CORD_WIDTH-1:0]);
      else n_pass++;
      n_checks++;
      if (cap_point[3][CORD_WIDTH-1:0] !== 13'h1000) $display("FAIL dir_sat_neg: got %h want 1000", cap_point[3][CORD_WIDTH-1:0]);
      else n_pass++;
      n_checks++;
      if (cap_point[4][CORD_WIDTH-1:0] !== 13'h1000) $display("FAIL dir_exact_m4096: got %h want 1000", cap_point[4][CORD_WIDTH-1:0]);
      else n_pass++;
      n_checks++;
      if (cap_point[5] !== '0 || cap_empty[5] !== 1'b1) $display("FAIL dir_empty: got %h empty=%b want 0 empty=1", cap_point[5], cap_empty[5]);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int s;
      int d;
      fill_random(1'b0);
      run_pass(0, 1'b0, s, d);
      n_checks++;
      if (d - s !== 201) $display("FAIL done_cycle: got %0d want 201", d - s);
      else n_pass++;
   endtask

   task automatic test_stall();
      int s;
      int d;
      fill_random(1'b0);
      run_pass(2, 1'b0, s, d);
   endtask

   task automatic test_random();
      int s;
      int d;
      for (int r = 0; r < 3; r++) begin
         fill_random(1'b1);
         run_pass(1, 1'b0, s, d);
      end
   endtask

   task automatic test_reset_mid();
      int s;
      int d;
      int budget = 0;
      fill_random(1'b0);
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.out_ready = 1'b1;
      while (!(bus.rd_en === 1'b1 && bus.rd_addr === IDX_WIDTH'(3)) && budget < 500) begin
         @(negedge clk);
         budget++;
      end
      n_checks++;
      if (budget >= 500) $display("FAIL reach_idx3: got timeout want read of index 3");
      else n_pass++;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rd_en !== 1'b0 || bus.rd_addr !== '0)
         $display("FAIL async_reset_ctrl: busy=%b done=%b rd_en=%b rd_addr=%0d want all 0", bus.busy, bus.done, bus.rd_en, bus.rd_addr);
      else n_pass++;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.out_idx !== '0 || bus.out_point !== '0 || bus.out_empty !== 1'b0)
         $display("FAIL async_reset_out: valid=%b idx=%0d point=%h empty=%b want all 0",
                  bus.out_valid, bus.out_idx, bus.out_point, bus.out_empty);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      fill_random(1'b1);
      run_pass(1, 1'b1, s, d);
   endtask

   initial begin
      n_checks = 0;
      n_pass = 0;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_stall();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
